// File: rtl/pwm_pkg.sv
// Shared definitions for the duty-cycle controller and the downstream
// two-digit display stage (which reuses duty_t for its num_i input).
package pwm_pkg;

    localparam int DUTY_MAX     = 100;
    localparam int DUTY_W       = 7;
    localparam int PERIOD_STEPS = 100;

    typedef logic [DUTY_W-1:0] duty_t;

    // Counter width that stays legal (>= 1 bit) when the terminal count is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debounce and a
// one-cycle press event on each accepted 0->1 transition.
// Optional auto-repeat while held: PWM_DUTY_CTRL_AUTO_REPEAT_EN.
module btn_debounce
    import pwm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20000,
    parameter int REPEAT_CYC   = 250000
) (
    input  logic clk,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("btn_debounce: DEBOUNCE_CYC must be >= 2");
    end
    if (REPEAT_CYC < 1) begin : g_bad_repeat
        $error("btn_debounce: REPEAT_CYC must be >= 1");
    end

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          rise;
    logic          rpt_fire;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_i;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (sync_q2 == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            level_q <= sync_q2;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Debounced level is about to flip high on this edge.
    assign rise = sync_q2 && !level_q && (cnt_q == CNT_LAST);

`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
    localparam int RW = cnt_width(REPEAT_CYC);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYC - 1);

    logic [RW-1:0] rpt_q;

    // Interval timer that runs only while the debounced level is held high.
    always_ff @(posedge clk) begin
        if (rst_i || !level_q) begin
            rpt_q <= '0;
        end else if (rpt_q == RPT_LAST) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_q + 1'b1;
        end
    end

    assign rpt_fire = level_q && (rpt_q == RPT_LAST);
`else
    assign rpt_fire = 1'b0;
`endif

    // Registered one-cycle press event.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            press_o <= 1'b0;
        end else begin
            press_o <= rise | rpt_fire;
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Two-button saturating duty control (0..100) with PWM generation.
// The PWM period latches the requested duty only at its wrap, so a new
// request never truncates or extends the running period.
// Optional auto-repeat while a button is held: PWM_DUTY_CTRL_AUTO_REPEAT_EN.
module pwm_duty_ctrl
    import pwm_pkg::*;
#(
    parameter int PRESCALE     = 1000,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int STEP         = 5,
    parameter int DUTY_INIT    = 50,
    parameter int REPEAT_CYC   = 250000
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              btn_up_i,
    input  logic              btn_dn_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              duty_valid_o,
    output logic              pwm_o
);

    localparam int PW = cnt_width(PRESCALE);
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [7:0]    STEP_8     = 8'(STEP);
    localparam logic [7:0]    MAX_8      = 8'(DUTY_MAX);
    localparam duty_t         INIT_D     = DUTY_W'(DUTY_INIT);
    localparam duty_t         PCNT_LAST  = DUTY_W'(PERIOD_STEPS - 1);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("pwm_duty_ctrl: PRESCALE must be >= 1");
    end
    if (STEP < 1 || STEP > DUTY_MAX) begin : g_bad_step
        $error("pwm_duty_ctrl: STEP must be 1..100");
    end
    if (DUTY_INIT < 0 || DUTY_INIT > DUTY_MAX) begin : g_bad_init
        $error("pwm_duty_ctrl: DUTY_INIT must be 0..100");
    end

    logic          up_ev;
    logic          dn_ev;
    logic [7:0]    sum_up;
    duty_t         duty_next;
    logic          duty_chg;
    logic [PW-1:0] presc_q;
    logic          tick;
    duty_t         pcnt_q;
    duty_t         shadow_q;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_CYC   (REPEAT_CYC)
    ) u_btn_up (
        .clk     (clk),
        .rst_i   (rst_i),
        .btn_i   (btn_up_i),
        .press_o (up_ev)
    );

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_CYC   (REPEAT_CYC)
    ) u_btn_dn (
        .clk     (clk),
        .rst_i   (rst_i),
        .btn_i   (btn_dn_i),
        .press_o (dn_ev)
    );

    // Saturating next duty; simultaneous up/down cancels out.
    always_comb begin
        sum_up    = {1'b0, duty_o} + STEP_8;
        duty_next = duty_o;
        if (up_ev && !dn_ev) begin
            duty_next = (sum_up > MAX_8) ? DUTY_W'(DUTY_MAX) : sum_up[DUTY_W-1:0];
        end else if (dn_ev && !up_ev) begin
            duty_next = ({1'b0, duty_o} < STEP_8) ? '0
                                                  : DUTY_W'({1'b0, duty_o} - STEP_8);
        end
        duty_chg = (duty_next != duty_o);
    end

    // Requested duty register; valid pulses only on a real value change.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            duty_o       <= INIT_D;
            duty_valid_o <= 1'b0;
        end else begin
            duty_o       <= duty_next;
            duty_valid_o <= duty_chg;
        end
    end

    assign tick = (presc_q == PRE_LAST);

    // Prescaler producing one tick every PRESCALE cycles.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Period counter; shadow duty is refreshed only at the period wrap.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            pcnt_q   <= '0;
            shadow_q <= INIT_D;
        end else if (tick) begin
            if (pcnt_q == PCNT_LAST) begin
                pcnt_q   <= '0;
                shadow_q <= duty_o;
            end else begin
                pcnt_q <= pcnt_q + 1'b1;
            end
        end
    end

    // Registered PWM compare.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            pwm_o <= 1'b0;
        end else begin
            pwm_o <= (pcnt_q < shadow_q);
        end
    end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
module tb_pwm_duty_ctrl;

    localparam int PRESCALE     = 2;
    localparam int DEBOUNCE_CYC = 4;
    localparam int STEP         = 5;
    localparam int DUTY_INIT    = 50;
    localparam int REPEAT_CYC   = 20;

    logic       clk;
    logic       rst_i;
    logic       btn_up_i;
    logic       btn_dn_i;
    logic [6:0] duty_o;
    logic       duty_valid_o;
    logic       pwm_o;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    pwm_duty_ctrl #(
        .PRESCALE     (PRESCALE),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .STEP         (STEP),
        .DUTY_INIT    (DUTY_INIT),
        .REPEAT_CYC   (REPEAT_CYC)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .btn_up_i     (btn_up_i),
        .btn_dn_i     (btn_dn_i),
        .duty_o       (duty_o),
        .duty_valid_o (duty_valid_o),
        .pwm_o        (pwm_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Button b: raw level reaches the debouncer two clocks late; the accepted
    // level flips after DEBOUNCE_CYC consecutive disagreeing cycles; a rise
    // gives an event in the following cycle.  PWM is computed from absolute
    // time since reset: step = (t / PRESCALE) mod 100, the period shadow is
    // the duty seen in the last cycle of the previous period.
    bit model_on = 0;
    int m_duty, m_shadow, m_t;
    bit m_valid, m_pwm;
    bit syn1[2], syn2[2], deb[2], ev[2], nev[2];
    int run[2], held[2];
    int nd, target;
    bit nv, npwm, rawb;

    always @(posedge clk) begin
        if (rst_i) begin
            model_on = 1;
            m_duty = DUTY_INIT; m_shadow = DUTY_INIT; m_t = 0;
            m_valid = 0; m_pwm = 0;
            for (int b = 0; b < 2; b++) begin
                syn1[b] = 0; syn2[b] = 0; deb[b] = 0; ev[b] = 0;
                run[b] = 0; held[b] = 0;
            end
        end else if (model_on) begin
            nd = m_duty; nv = 0;
            if (ev[0] != ev[1]) begin
                if (ev[0]) target = (m_duty + STEP > 100) ? 100 : m_duty + STEP;
                else       target = (m_duty - STEP < 0)   ? 0   : m_duty - STEP;
                if (target != m_duty) begin nd = target; nv = 1; end
            end
            for (int b = 0; b < 2; b++) begin
                nev[b] = 0;
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
                if (deb[b]) begin
                    held[b]++;
                    if (held[b] == REPEAT_CYC) begin nev[b] = 1; held[b] = 0; end
                end else held[b] = 0;
`endif
                if (syn2[b] != deb[b]) begin
                    run[b]++;
                    if (run[b] == DEBOUNCE_CYC) begin
                        deb[b] = syn2[b]; run[b] = 0;
                        if (deb[b]) nev[b] = 1;
                    end
                end else run[b] = 0;
                rawb = (b == 0) ? btn_up_i : btn_dn_i;
                syn2[b] = syn1[b]; syn1[b] = rawb;
            end
            npwm = ((m_t / PRESCALE) % 100) < m_shadow;
            if ((m_t + 1) % (100 * PRESCALE) == 0) m_shadow = m_duty;
            m_t++;
            m_duty = nd; m_valid = nv; m_pwm = npwm;
            ev[0] = nev[0]; ev[1] = nev[1];
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (model_on) begin
            checks++;
            if (duty_o != m_duty) begin
                errors++;
                $display("FAIL model_duty t=%0t: got %0d expected %0d", $time, duty_o, m_duty);
            end
            checks++;
            if (duty_valid_o != m_valid) begin
                errors++;
                $display("FAIL model_valid t=%0t: got %0d expected %0d", $time, duty_valid_o, m_valid);
            end
            checks++;
            if (pwm_o != m_pwm) begin
                errors++;
                $display("FAIL model_pwm t=%0t: got %0d expected %0d", $time, pwm_o, m_pwm);
            end
            if (duty_valid_o) vcount++;
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick_n(3);
        rst_i = 1'b0;
    endtask

    task automatic press(input bit up, input bit dn, input int hold, input int gap);
        btn_up_i = up; btn_dn_i = dn;
        tick_n(hold);
        btn_up_i = 1'b0; btn_dn_i = 1'b0;
        tick_n(gap);
    endtask

    task automatic count_level(input bit lvl, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (pwm_o == lvl) cnt++;
        end
        #1;
    endtask

    initial begin
        int v0, w, h1, h2, cnt, hold;
        rst_i = 1'b1; btn_up_i = 1'b0; btn_dn_i = 1'b0;

        // 1: reset values and first PWM high
        do_reset();
        @(negedge clk);
        chk("reset_duty", duty_o, 50);
        chk("reset_valid", duty_valid_o, 0);
        chk("reset_pwm", pwm_o, 0);
        w = 0;
        while (!pwm_o && w < 6) begin @(negedge clk); w++; end
        chk("first_pwm_high", pwm_o, 1);
        tick_n(1);

        // 5: PWM at 50, change to 55 mid-period
        do_reset();
        fork
            begin
                count_level(1'b1, 200, h1);
                count_level(1'b1, 200, h2);
            end
            begin
                tick_n(30);
                press(1'b1, 1'b0, 12, 0);
            end
        join
        chk("pwm_period0_high", h1, 100);
        chk("pwm_period1_high", h2, 110);
        chk("duty_after_mid_change", duty_o, 55);

        // 2: single press (or auto-repeat)
        do_reset();
        v0 = vcount;
`ifdef PWM_DUTY_CTRL_AUTO_REPEAT_EN
        press(1'b1, 1'b0, 50, 20);
        chk("repeat_pulses", vcount - v0, 3);
        chk("repeat_duty", duty_o, 65);
`else
        press(1'b1, 1'b0, 12, 20);
        chk("single_press_pulses", vcount - v0, 1);
        chk("single_press_duty", duty_o, 55);
`endif

        // 3: short glitches rejected
        do_reset();
        v0 = vcount;
        press(1'b0, 1'b1, 1, 3);
        press(1'b0, 1'b1, 2, 3);
        press(1'b0, 1'b1, 3, 12);
        chk("glitch_pulses", vcount - v0, 0);
        chk("glitch_duty", duty_o, 50);

        // 4: saturation at both ends
        do_reset();
        repeat (10) press(1'b1, 1'b0, 8, 8);
        chk("sat_high_reached", duty_o, 100);
        v0 = vcount;
        press(1'b1, 1'b0, 8, 8);
        chk("sat_high_pulses", vcount - v0, 0);
        chk("sat_high_duty", duty_o, 100);
        tick_n(200);
        count_level(1'b0, 200, cnt);
        chk("duty100_low_cycles", cnt, 0);
        repeat (19) press(1'b0, 1'b1, 8, 8);
        chk("down_to_5", duty_o, 5);
        v0 = vcount;
        press(1'b0, 1'b1, 8, 8);
        press(1'b0, 1'b1, 8, 8);
        chk("sat_low_pulses", vcount - v0, 1);
        chk("sat_low_duty", duty_o, 0);
        tick_n(200);
        count_level(1'b1, 200, cnt);
        chk("duty0_high_cycles", cnt, 0);

        // 6: simultaneous events cancel
        do_reset();
        v0 = vcount;
        press(1'b1, 1'b1, 12, 20);
        chk("both_pulses", vcount - v0, 0);
        chk("both_duty", duty_o, 50);

        // 6: reset during debounce discards progress
        do_reset();
        btn_up_i = 1'b1;
        tick_n(4);
        rst_i = 1'b1;
        tick_n(3);
        rst_i = 1'b0;
        v0 = vcount;
        tick_n(3);
        btn_up_i = 1'b0;
        tick_n(12);
        chk("mid_debounce_reset_pulses", vcount - v0, 0);
        chk("mid_debounce_reset_duty", duty_o, 50);

        // Random button activity, checked by the model every cycle
        do_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst_i = 1'b1;
                tick_n(1);
                rst_i = 1'b0;
            end
            btn_up_i = 1'($urandom_range(0, 1));
            btn_dn_i = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 9);
            tick_n(hold);
        end
        btn_up_i = 1'b0; btn_dn_i = 1'b0;
        tick_n(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
- Upstream stage of the two-digit seven-segment display driver.
- Turns two push-buttons into a saturating duty-cycle value of 0..100, presented as a 7-bit binary number on duty_o; this feeds the display stage's num_i.
- Generates the PWM output from the same value.
- Single clock domain, synchronous logic only.

Parameters:
- PRESCALE, 1000, clk cycles per PWM tick (minimum 1).
- DEBOUNCE_CYC, 20000, consecutive stable cycles required to accept a button level change (minimum 2).
- STEP, 5, duty increment/decrement per accepted press (1..100).
- DUTY_INIT, 50, duty value after reset (0..100).
- REPEAT_CYC, 250000, auto-repeat interval in clk cycles (used only with AUTO_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- rst_i  in  1  reset: synchronous, active-high, single clock domain.
- btn_up_i  in  1  raw asynchronous "increase" button, active-high.
- btn_dn_i  in  1  raw asynchronous "decrease" button, active-high.
- duty_o  out  7  requested duty, binary 0..100; drives the display stage's num_i.
- duty_valid_o  out  1  one-cycle pulse in the cycle duty_o takes a new value.
- pwm_o  out  1  PWM waveform.

Behaviour:
- Reset values (rst_i sampled high on a clk edge):
  - duty_o = DUTY_INIT and the active (shadow) duty = DUTY_INIT.
  - duty_valid_o = 0, pwm_o = 0.
  - Prescaler, period and debounce counters = 0.
  - Synchronizers and debounced levels = 0.
  - Reset asserted mid-debounce or mid-period abandons all progress.
- Synchronizer: each button passes through a 2-flop synchronizer before debounce.
- Debounce, per button:
  - A counter increments while the synchronized level differs from the debounced level.
  - The counter clears whenever the two levels match.
  - When the counter equals DEBOUNCE_CYC-1 and the levels still differ, the debounced level flips on the next edge and the counter clears.
  - A 0->1 transition of the debounced level produces a one-cycle press event.
  - A 1->0 transition produces no event.
  - Glitches shorter than DEBOUNCE_CYC cycles are ignored.
- Duty update:
  - Latency: duty_o updates on the edge after the press-event cycle, and duty_valid_o is high in that same cycle.
  - Up event only: duty = min(duty+STEP, 100), with the add done in 8 bits.
  - Down event only: duty = max(duty-STEP, 0), with no underflow wrap.
  - Up and down events in the same cycle: no change, no pulse.
  - Saturated request (already 100 and up, or already 0 and down): no change, no pulse. duty_valid_o pulses only on an actual change of value.
- PWM:
  - tick = 1 for one cycle when the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - The period counter pcnt counts 0..99 on each tick and wraps 99->0.
  - The shadow duty loads from duty_o when pcnt wraps to 0. Mid-period duty changes therefore never truncate or extend the current period.
  - pwm_o is registered: pwm_o = (pcnt < shadow).
  - shadow = 0 gives constant low; shadow = 100 gives constant high.
  - Period = 100*PRESCALE clk cycles.

Optional Feature:
- Macro: PWM_DUTY_CTRL_AUTO_REPEAT_EN.
- Defined:
  - While a debounced button remains high, an additional press event fires every REPEAT_CYC cycles, measured from the initial press event.
  - The repeat counter clears on release and on reset.
  - Simultaneous-event and saturation rules are unchanged.
- Undefined:
  - Exactly one event per press.
  - REPEAT_CYC is unused and no repeat counter is synthesized.

Decomposition:
- Shared package pwm_pkg holds:
  - DUTY_MAX = 100.
  - DUTY_W = 7.
  - PERIOD_STEPS = 100.
  - A typedef for the 7-bit duty type; the display stage reuses these.
- Sub-module btn_debounce (synchronizer, debounce counter, press-event generator, optional repeat) is instantiated twice.
- Saturating arithmetic and PWM live in the top level.

Test Plan:
Bench parameters: PRESCALE=2, DEBOUNCE_CYC=4, STEP=5, DUTY_INIT=50, REPEAT_CYC=20.
1. Reset held 3 cycles then released -> duty_o=50, duty_valid_o=0, pwm_o=0; the first pwm_o high appears within 2 cycles after the first tick.
2. btn_up_i high 12 cycles -> exactly one duty_valid_o pulse, duty_o=55 (macro undefined). With the macro defined and the button held 50 cycles -> 55, then 60, then 65 at 20-cycle spacing.
3. btn_dn_i pulses 1, 2 and 3 cycles wide, separated by 3 low cycles -> duty_o stays 50, no duty_valid_o.
4. Saturation: preset duty 100 via 10 up presses, then press up -> duty_o stays 100, no pulse. From 5, two down presses -> 0, then stays 0 with only one pulse.
5. PWM at duty 50 -> pwm_o high 100 clk, low 100 clk, repeating. Change to 55 at pcnt=20 -> the current period keeps 50 high ticks, the next period has 55. Duty 0 -> pwm_o never high; duty 100 -> pwm_o never low.
6. Up and down debounced events in the same cycle -> no change, no pulse. Reset asserted at debounce count 2 -> no event after reset deasserts, even with the button still high for fewer than 4 further cycles.
